// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
//   Execute stage fed by the datapath shifter. Combines the latched A operand
//   (optionally forced to zero) with the shifter output as operand B, runs the
//   selected ALU operation and captures the result into the C register and
//   the {Z,N,V} condition codes into the status register. The result is
//   offered to writeback through a single-entry valid/ready pipeline
//   register, so the stage sustains one operation per cycle and stalls
//   cleanly under backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and controls valid this cycle
//   in_ready   stage can accept an operation (combinational, no in_valid path)
//   ain        A operand
//   sout       B operand from the shifter
//   asel       1: force A operand to zero
//   alu_op     00 ADD, 01 SUB, 10 AND, 11 MVN (~B)
//   loadc      capture result into C on accept
//   loads      capture {Z,N,V} into status on accept
//   out_valid  c_out/status reflect a completed operation
//   out_ready  downstream consumes the result this cycle
//   c_out      C register
//   status     {Z,N,V} register
// ---------------------------------------------------------------------------
module alu_exec_stage #(
  parameter int WIDTH    = 16,
  parameter int STATUS_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    ain,
  input  logic [WIDTH-1:0]    sout,
  input  logic                asel,
  input  logic [1:0]          alu_op,
  input  logic                loadc,
  input  logic                loads,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    c_out,
  output logic [STATUS_W-1:0] status
);

  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  logic [WIDTH-1:0]    r_c;
  logic [STATUS_W-1:0] r_status;
  logic                r_out_valid;

  logic [WIDTH-1:0]    w_a_eff;
  logic [WIDTH-1:0]    w_r;
  logic                w_z;
  logic                w_n;
  logic                w_v;
  logic [STATUS_W-1:0] w_flags;
  logic                w_in_ready;
  logic                w_accept;

  // ALU datapath; arithmetic wraps modulo 2^WIDTH, carry is discarded.
  always_comb begin
    w_a_eff = asel ? '0 : ain;
    w_r     = '0;
    w_v     = 1'b0;
    case (alu_op)
      OP_ADD: begin
        w_r = w_a_eff + sout;
        // Signed overflow: like-signed operands produce a differently-signed sum.
        w_v = (w_a_eff[MSB] == sout[MSB]) && (w_r[MSB] != w_a_eff[MSB]);
      end
      OP_SUB: begin
        w_r = w_a_eff - sout;
        // Signed overflow: unlike-signed operands and the sign of A is lost.
        w_v = (w_a_eff[MSB] != sout[MSB]) && (w_r[MSB] != w_a_eff[MSB]);
      end
      OP_AND: w_r = w_a_eff & sout;
      OP_MVN: w_r = ~sout;
      default: w_r = '0;
    endcase
    w_z     = (w_r == '0);
    w_n     = w_r[MSB];
    w_flags = {w_z, w_n, w_v};
  end

  // A held result blocks new work only while downstream is not taking it.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c         <= '0;
      r_status    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        // An accept with neither load enable still produces a bubble token.
        if (loadc) r_c      <= w_r;
        if (loads) r_status <= w_flags;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        // Consume without replacement: C and status keep their contents.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign c_out     = r_c;
  assign status    = r_status;

endmodule

// File: tb/tb_alu_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_stage
//   Directed-vector bench for alu_exec_stage. Inputs are driven 1 time unit
//   after the rising edge and outputs are sampled at the same point, away
//   from the active edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_exec_stage;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] MVN = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ain;
  logic [15:0] sout;
  logic        asel;
  logic [1:0]  alu_op;
  logic        loadc;
  logic        loads;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c_out;
  logic [2:0]  status;

  int checks;
  int failures;

  alu_exec_stage #(.WIDTH(16), .STATUS_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .sout      (sout),
    .asel      (asel),
    .alu_op    (alu_op),
    .loadc     (loadc),
    .loads     (loads),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic as,
                       input logic [1:0] op, input logic lc, input logic ls);
    in_valid = 1'b1;
    ain      = a;
    sout     = b;
    asel     = as;
    alu_op   = op;
    loadc    = lc;
    loads    = ls;
  endtask

  // Issue one operation with out_ready=1 and check the registered result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic as, input logic [1:0] op, input logic lc,
                        input logic ls, input logic [15:0] exp_c, input logic [2:0] exp_s);
    drive(a, b, as, op, lc, ls);
    out_ready = 1'b1;
    step();
    check({tag, ".c"}, 32'(c_out), 32'(exp_c));
    check({tag, ".s"}, 32'(status), 32'(exp_s));
    check({tag, ".v"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ain       = '0;
    sout      = '0;
    asel      = 1'b0;
    alu_op    = ADD;
    loadc     = 1'b0;
    loads     = 1'b0;

    // Reset held for two cycles, then released with nothing issued.
    step();
    step();
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle.c", 32'(c_out), 32'h0000);
    check("idle.s", 32'(status), 32'd0);
    check("idle.v", 32'(out_valid), 32'd0);
    check("idle.in_ready", 32'(in_ready), 32'd1);

    // Functional vectors.
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, ADD, 1'b1, 1'b1, 16'h8000, 3'b011);
    run_op("cmp_eq",  16'h1234, 16'h1234, 1'b0, SUB, 1'b0, 1'b1, 16'h8000, 3'b100);
    run_op("and",     16'hF0F0, 16'h0FF0, 1'b0, AND, 1'b1, 1'b1, 16'h00F0, 3'b000);
    run_op("mvn",     16'hF0F0, 16'h0000, 1'b1, MVN, 1'b1, 1'b1, 16'hFFFF, 3'b010);

    // Consume with nothing new: valid drops, registers keep their contents.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("consume.v", 32'(out_valid), 32'd0);
    check("consume.c", 32'(c_out), 32'hFFFF);
    check("consume.s", 32'(status), 32'b010);

    // Backpressure: 1+2 lands, then 5+5 is stalled for three cycles.
    drive(16'h0001, 16'h0002, 1'b0, ADD, 1'b1, 1'b1);
    out_ready = 1'b0;
    step();
    check("bp.first.c", 32'(c_out), 32'h0003);
    check("bp.first.v", 32'(out_valid), 32'd1);
    drive(16'h0005, 16'h0005, 1'b0, ADD, 1'b1, 1'b1);
    check("bp.in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp.hold%0d.c", i), 32'(c_out), 32'h0003);
      check($sformatf("bp.hold%0d.v", i), 32'(out_valid), 32'd1);
      check($sformatf("bp.hold%0d.rdy", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp.release.c", 32'(c_out), 32'h000A);
    check("bp.release.v", 32'(out_valid), 32'd1);

    // Back-to-back throughput with out_ready=1; one result every cycle.
    run_op("b2b_sub",     16'h000A, 16'h0003, 1'b0, SUB, 1'b1, 1'b1, 16'h0007, 3'b000);
    run_op("b2b_add_v",   16'h8000, 16'h8000, 1'b0, ADD, 1'b1, 1'b1, 16'h0000, 3'b101);
    run_op("b2b_sub_v",   16'h8000, 16'h0001, 1'b0, SUB, 1'b1, 1'b1, 16'h7FFF, 3'b001);
    run_op("b2b_nos",     16'h0000, 16'h0001, 1'b0, SUB, 1'b1, 1'b0, 16'hFFFF, 3'b001);
    run_op("b2b_asel",    16'h1234, 16'h0001, 1'b1, SUB, 1'b1, 1'b1, 16'hFFFF, 3'b010);
    run_op("b2b_bubble",  16'h1111, 16'h2222, 1'b0, ADD, 1'b0, 1'b0, 16'hFFFF, 3'b010);

    // Async reset while a result is stalled.
    drive(16'h0000, 16'h0000, 1'b0, MVN, 1'b1, 1'b1);
    out_ready = 1'b0;
    step();
    check("stall.c", 32'(c_out), 32'hFFFF);
    check("stall.v", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.v", 32'(out_valid), 32'd0);
    check("async_rst.c", 32'(c_out), 32'h0000);
    check("async_rst.s", 32'(status), 32'd0);
    check("async_rst.in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage directly downstream of the 16-bit shifter in the RISC datapath.
- Consumes the shifter output `sout` as operand B and the latched A operand, and performs the ALU operation.
- Registers the result into the C register and the condition codes into the status register.
- Presents the result to writeback through a valid/ready handshake, so the controller FSM can stall the datapath.

Parameters:
- WIDTH, 16, datapath width; must match shifter width.
- STATUS_W, 3, status register width; fixed order {Z,N,V}.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and controls are valid this cycle
- in_ready  output  1  stage can accept an operation this cycle
- ain  input  WIDTH  A operand (latched A register)
- sout  input  WIDTH  B operand from the shifter
- asel  input  1  1: force A operand to zero
- alu_op  input  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~B)
- loadc  input  1  capture result into C on accept
- loads  input  1  capture {Z,N,V} into status on accept
- out_valid  output  1  c_out/status reflect a completed operation
- out_ready  input  1  downstream consumes the result this cycle
- c_out  output  WIDTH  C register
- status  output  STATUS_W  {Z,N,V} register

Behaviour:
- Reset (rst_n low, asynchronous):
  - c_out=0, status=3'b000, out_valid=0.
  - in_ready follows the rule below, so it is 1 while in reset.
  - Deassertion is sampled on clk.
- Operand A: A_eff = asel ? 0 : ain. Operand B = sout.
- Arithmetic is modulo 2^WIDTH; carry out is discarded.
  - ADD: R = A_eff + B. V = (A_eff[15]==B[15]) && (R[15]!=A_eff[15]).
  - SUB: R = A_eff - B. V = (A_eff[15]!=B[15]) && (R[15]!=A_eff[15]).
  - AND: R = A_eff & B, V = 0.
  - MVN: R = ~B, V = 0. A is ignored.
  - Z = (R==0). N = R[15].
- Handshake (single-entry pipeline register):
  - in_ready = !out_valid || out_ready. This is combinational; there is no path from in_valid to in_ready.
  - accept = in_valid && in_ready.
  - On accept:
    - c_out <= R if loadc, else c_out holds.
    - status <= {Z,N,V} if loads, else status holds.
    - out_valid <= 1.
    - An accept with loadc=loads=0 still sets out_valid and acts as a bubble token.
  - If out_valid && out_ready and no accept in the same cycle: out_valid <= 0. c_out and status keep their values; the registers are not cleared on consume.
  - If out_valid && out_ready and accept in the same cycle: the new result replaces the old one and out_valid stays 1. This gives full throughput of 1 op/cycle.
  - If out_valid && !out_ready: in_ready=0, so new inputs are ignored. c_out, status and out_valid are held stable until consumed.
- Latency: 1 cycle from accept to out_valid/c_out update.
- Inputs are don't-care when in_valid=0. No state changes without accept, except out_valid clearing on consume.
- Reset asserted mid-stall discards the held result immediately: out_valid=0, c_out=0.
- Status is architecturally visible and persists across operations that have loads=0. This is required for CMP (SUB with loadc=0, loads=1).

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release with in_valid=0 -> c_out=0x0000, status=000, out_valid=0, in_ready=1.
- ADD overflow: ain=0x7FFF, sout=0x0001, ADD, loadc=loads=1, out_ready=1 -> next cycle c_out=0x8000, status={Z0,N1,V1}, out_valid=1.
- CMP equal: ain=0x1234, sout=0x1234, SUB, loadc=0, loads=1, with prior c_out=0x8000 -> c_out stays 0x8000, status=100.
- AND, then MVN with asel=1:
  - ain=0xF0F0, sout=0x0FF0, AND -> c_out=0x00F0, status=000.
  - Then sout=0x0000, MVN -> c_out=0xFFFF, status=010, V=0.
- Backpressure:
  - Issue ADD 1+2, then hold out_ready=0 for 3 cycles while in_valid=1 with ain=5, sout=5 -> in_ready=0, c_out stays 0x0003, out_valid=1 throughout.
  - Raise out_ready -> the same cycle accepts and the next cycle shows c_out=0x000A.
  - Back-to-back ops with out_ready=1 -> one result per cycle, no gaps.
- Async reset mid-stall: assert rst_n=0 between clock edges while out_valid=1, out_ready=0 -> out_valid, c_out and status go to 0 before the next edge.
